fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage feeding the decode stage's Instruction/PC inputs. Owns the PC,
//  issues word reads to instruction memory over a req/ack handshake, and presents one
//  instruction per cycle with a valid flag. Applies PC_Src redirects and stalls from decode.
//  Halts permanently on an instruction whose stop bit [31] is set.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  PC_INC    4              sequential PC increment (word-aligned byte addresses)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-low
//  imem_req     out  1   read request; held high until imem_ack
//  imem_addr    out  32  read address; stable while imem_req high
//  imem_ack     in   1   read complete; imem_rdata valid same cycle
//  imem_rdata   in   32  instruction word
//  id_stall     in   1   decode cannot accept; hold if_* outputs
//  redirect     in   1   control-flow change this cycle
//  pc_src       in   2   01 sequential, 10 jump_addr, 11 reg_target, 00 treat as sequential
//  jump_addr    in   32  J-type target
//  reg_target   in   32  register-indirect target (I-type op 00100)
//  if_valid     out  1   if_instr/if_pc hold a live instruction
//  if_instr     out  32  instruction to decode
//  if_pc        out  32  address of if_instr
//  halted       out  1   stop instruction fetched; no further requests
// BEHAVIOUR
//  Reset (rst=0, async): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=0, if_valid=0,
//   if_instr=0, if_pc=0, halted=0, skid buffer empty, squash=0. Reset mid-transaction drops
//   the outstanding request; memory must tolerate req deasserting before ack.
//  States: IDLE -> REQ (1 cycle after reset release). REQ: imem_req=1, imem_addr=pc;
//   on imem_ack -> REQ again (next pc) or HALT; if output and skid both full -> WAIT_OUT.
//   WAIT_OUT: imem_req=0 until skid drains, then REQ. HALT: terminal until reset.
//  Max one outstanding request. No new request issued while skid buffer is full.
//  Response routing on ack: if squash=1 discard and clear squash; else if output empty or
//   (if_valid && !id_stall) load output regs (if_instr=rdata, if_pc=request addr, if_valid=1);
//   else write 1-entry skid buffer. Output refills from skid before memory (program order).
//  pc update on accepted ack: pc <= pc + PC_INC (32-bit wrap, 32'hFFFF_FFFC -> 0).
//  Stall: id_stall=1 with if_valid=1 holds if_* unchanged; id_stall=1 with if_valid=0 no effect.
//   Output consumed when if_valid && !id_stall; then if_valid drops unless refilled same cycle.
//  Redirect (pc_src 10/11) beats stall: next cycle pc=target, if_valid=0, skid cleared;
//   if request outstanding and not acked this cycle, squash=1 and req held until ack
//   (addr unchanged) then new request at target; if acked same cycle, data discarded.
//   pc_src 01/00 with redirect=1: no effect. Redirect in HALT ignored.
//  Stop: when an instruction with bit[31]=1 is accepted from memory, it is delivered normally,
//   halted=1 next cycle, state=HALT, imem_req=0; the skid may still drain its entry.
//  Redirect same cycle as stop-word ack: redirect wins, word discarded, no halt.
//  Latency: ack in cycle N -> if_valid=1 in cycle N+1 (registered). Zero-wait memory gives
//   one instruction per cycle.
// TESTING
//  Zero-wait mem, no stall, RESET_PC=0 -> if_pc 0,4,8,12 on consecutive cycles, if_valid=1.
//  ack delayed 3 cycles -> imem_req/imem_addr stable 3 cycles; if_valid pulses once per word.
//  id_stall=1 for 4 cycles at if_pc=8 -> if_pc/if_instr held at 8; skid holds 12; release
//   -> 8 consumed, then 12, then 16 in order, no loss or duplication.
//  redirect=1, pc_src=10, jump_addr=32'h0100_0040 while request for 20 outstanding -> word 20
//   squashed, next if_pc=32'h0100_0040, if_valid=0 for redirect cycle+1.
//  Fetch word 32'h8000_0000 at pc=12 -> delivered with if_pc=12, halted=1, imem_req stays 0.
//  Assert rst=0 mid-WAIT -> all outputs 0 immediately; after release first addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake and
// hands one instruction per cycle to decode through an output register plus 1-entry skid.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INC   = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        redirect,
   input  logic [1:0]  pc_src,
   input  logic [31:0] jump_addr,
   input  logic [31:0] reg_target,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        halted
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_OUT, S_HALT} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic        r_valid, w_valid_nxt;
   logic [31:0] r_instr, w_instr_nxt;
   logic [31:0] r_ipc, w_ipc_nxt;
   logic        r_skid_v, w_skid_v_nxt;
   logic [31:0] r_skid_instr, w_skid_instr_nxt;
   logic [31:0] r_skid_pc, w_skid_pc_nxt;
   logic        r_squash, w_squash_nxt;

   logic        w_redir, w_ack, w_accept, w_out_free;
   logic [31:0] w_target;

   assign w_redir    = redirect && pc_src[1] && (r_state != S_HALT);
   assign w_target   = pc_src[0] ? reg_target : jump_addr;
   assign w_ack      = (r_state == S_REQ) && imem_ack;
   assign w_accept   = w_ack && !r_squash && !w_redir;
   assign w_out_free = !r_valid || !id_stall;

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_valid_nxt      = r_valid;
      w_instr_nxt      = r_instr;
      w_ipc_nxt        = r_ipc;
      w_skid_v_nxt     = r_skid_v;
      w_skid_instr_nxt = r_skid_instr;
      w_skid_pc_nxt    = r_skid_pc;
      w_squash_nxt     = r_squash;
      if (w_redir) begin
         // An unacked request cannot be withdrawn: keep it up and drop its data on ack.
         w_pc_nxt     = w_target;
         w_valid_nxt  = 1'b0;
         w_skid_v_nxt = 1'b0;
         w_squash_nxt = (r_state == S_REQ) && !imem_ack;
         w_state_nxt  = S_REQ;
      end else begin
         if (w_out_free) begin
            if (r_skid_v) begin
               w_valid_nxt  = 1'b1;
               w_instr_nxt  = r_skid_instr;
               w_ipc_nxt    = r_skid_pc;
               w_skid_v_nxt = 1'b0;
            end else if (w_accept) begin
               w_valid_nxt = 1'b1;
               w_instr_nxt = imem_rdata;
               w_ipc_nxt   = r_addr;
            end else begin
               w_valid_nxt = 1'b0;
            end
         end
         if (w_accept && (!w_out_free || r_skid_v)) begin
            w_skid_v_nxt     = 1'b1;
            w_skid_instr_nxt = imem_rdata;
            w_skid_pc_nxt    = r_addr;
         end
         if (w_ack && r_squash)
            w_squash_nxt = 1'b0;
         if (w_accept)
            w_pc_nxt = r_pc + PC_INC;
         case (r_state)
            S_IDLE:     w_state_nxt = S_REQ;
            S_REQ: begin
               if (w_accept && imem_rdata[31])
                  w_state_nxt = S_HALT;
               else if (w_accept && w_valid_nxt && w_skid_v_nxt)
                  w_state_nxt = S_WAIT_OUT;
            end
            S_WAIT_OUT: if (!w_skid_v_nxt) w_state_nxt = S_REQ;
            S_HALT:     w_state_nxt = S_HALT;
         endcase
      end
      // The presented address only moves once the outstanding request completes.
      if ((r_state == S_REQ) && !imem_ack)
         w_addr_nxt = r_addr;
      else
         w_addr_nxt = w_pc_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_addr       <= '0;
         r_valid      <= 1'b0;
         r_instr      <= '0;
         r_ipc        <= '0;
         r_skid_v     <= 1'b0;
         r_skid_instr <= '0;
         r_skid_pc    <= '0;
         r_squash     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_addr       <= w_addr_nxt;
         r_valid      <= w_valid_nxt;
         r_instr      <= w_instr_nxt;
         r_ipc        <= w_ipc_nxt;
         r_skid_v     <= w_skid_v_nxt;
         r_skid_instr <= w_skid_instr_nxt;
         r_skid_pc    <= w_skid_pc_nxt;
         r_squash     <= w_squash_nxt;
      end
   end

   assign imem_req  = (r_state == S_REQ);
   assign imem_addr = r_addr;
   assign if_valid  = r_valid;
   assign if_instr  = r_instr;
   assign if_pc     = r_ipc;
   assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a delay-programmable instruction memory responder.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        id_stall = 1'b0;
   logic        redirect = 1'b0;
   logic [1:0]  pc_src = 2'b01;
   logic [31:0] jump_addr = '0;
   logic [31:0] reg_target = '0;
   logic        if_valid, halted;
   logic [31:0] if_instr, if_pc;

   logic [3:0]  mem_delay = 4'd0;
   logic [3:0]  wcnt = 4'd0;
   logic        stop_en = 1'b0;
   int          errs = 0;
   int          checks = 0;

   fetch_stage #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .id_stall(id_stall), .redirect(redirect), .pc_src(pc_src),
      .jump_addr(jump_addr), .reg_target(reg_target),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .halted(halted)
   );

   always #5 clk = ~clk;

   // memory: ack after mem_delay waiting cycles; word = 0x11 tag over the low 24 address bits
   assign imem_ack   = imem_req && (wcnt == mem_delay);
   assign imem_rdata = (stop_en && imem_addr == 32'd12) ? 32'h8000_0000 : {8'h11, imem_addr[23:0]};
   always @(posedge clk) begin
      if (!imem_req || imem_ack) wcnt <= 4'd0;
      else                       wcnt <= wcnt + 4'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   initial begin
      logic found;
      // ---- reset values and zero-wait stream ----
      step();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      do_reset();
      step();
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'd0);
      chk("first_valid", {31'd0, if_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("seq_valid", {31'd0, if_valid}, 32'd1);
         chk("seq_pc", if_pc, 32'(i * 4));
         chk("seq_instr", if_instr, 32'h1100_0000 | 32'(i * 4));
      end
      redirect = 1'b1; pc_src = 2'b01;
      step();
      redirect = 1'b0;
      chk("seqsrc_pc", if_pc, 32'd16);
      chk("seqsrc_valid", {31'd0, if_valid}, 32'd1);
      redirect = 1'b1; pc_src = 2'b11; reg_target = 32'h0000_0200;
      step();
      redirect = 1'b0; pc_src = 2'b01;
      chk("rt_valid0", {31'd0, if_valid}, 32'd0);
      chk("rt_addr", imem_addr, 32'h0000_0200);
      step();
      chk("rt_valid1", {31'd0, if_valid}, 32'd1);
      chk("rt_pc", if_pc, 32'h0000_0200);
      chk("rt_instr", if_instr, 32'h1100_0200);

      // ---- stall with skid ----
      do_reset();
      step(); step(); step(); step();
      chk("st_pc8", if_pc, 32'd8);
      id_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("st_hold_pc", if_pc, 32'd8);
         chk("st_hold_instr", if_instr, 32'h1100_0008);
         chk("st_hold_valid", {31'd0, if_valid}, 32'd1);
         chk("st_noreq", {31'd0, imem_req}, 32'd0);
      end
      id_stall = 1'b0;
      step();
      chk("st_pc12", if_pc, 32'd12);
      chk("st_instr12", if_instr, 32'h1100_000c);
      chk("st_addr16", imem_addr, 32'd16);
      step();
      chk("st_pc16", if_pc, 32'd16);
      step();
      chk("st_pc20", if_pc, 32'd20);

      // ---- 3-cycle ack delay ----
      mem_delay = 4'd3;
      do_reset();
      step();
      for (int i = 0; i < 4; i++) begin
         chk("dl_req", {31'd0, imem_req}, 32'd1);
         chk("dl_addr", imem_addr, 32'd0);
         chk("dl_valid", {31'd0, if_valid}, 32'd0);
         step();
      end
      chk("dl_valid1", {31'd0, if_valid}, 32'd1);
      chk("dl_pc", if_pc, 32'd0);
      chk("dl_addr4", imem_addr, 32'd4);
      step();
      chk("dl_pulse", {31'd0, if_valid}, 32'd0);

      // ---- redirect with outstanding request squashed ----
      mem_delay = 4'd1;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (imem_req && imem_addr == 32'd20) found = 1'b1;
      end
      chk("rd_find20", {31'd0, found}, 32'd1);
      chk("rd_pc16", if_pc, 32'd16);
      redirect = 1'b1; pc_src = 2'b10; jump_addr = 32'h0100_0040;
      step();
      redirect = 1'b0; pc_src = 2'b01;
      chk("rd_valid_a", {31'd0, if_valid}, 32'd0);
      chk("rd_hold_addr", imem_addr, 32'd20);
      chk("rd_hold_req", {31'd0, imem_req}, 32'd1);
      step();
      chk("rd_valid_b", {31'd0, if_valid}, 32'd0);
      chk("rd_new_addr", imem_addr, 32'h0100_0040);
      step();
      chk("rd_valid_c", {31'd0, if_valid}, 32'd0);
      step();
      chk("rd_valid_d", {31'd0, if_valid}, 32'd1);
      chk("rd_pc", if_pc, 32'h0100_0040);
      chk("rd_instr", if_instr, 32'h1100_0040);

      // ---- stop word halts ----
      mem_delay = 4'd0;
      stop_en = 1'b1;
      do_reset();
      step(); step(); step(); step();
      chk("hl_pc8", if_pc, 32'd8);
      step();
      chk("hl_pc", if_pc, 32'd12);
      chk("hl_instr", if_instr, 32'h8000_0000);
      chk("hl_valid", {31'd0, if_valid}, 32'd1);
      chk("hl_halted", {31'd0, halted}, 32'd1);
      chk("hl_req", {31'd0, imem_req}, 32'd0);
      redirect = 1'b1; pc_src = 2'b10; jump_addr = 32'h0000_0400;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hl_stay", {31'd0, halted}, 32'd1);
         chk("hl_noreq", {31'd0, imem_req}, 32'd0);
         chk("hl_drained", {31'd0, if_valid}, 32'd0);
      end
      redirect = 1'b0; pc_src = 2'b01;
      stop_en = 1'b0;

      // ---- asynchronous reset while parked in WAIT_OUT ----
      id_stall = 1'b1;
      do_reset();
      step(); step(); step();
      chk("wr_req", {31'd0, imem_req}, 32'd0);
      chk("wr_valid", {31'd0, if_valid}, 32'd1);
      chk("wr_instr", if_instr, 32'h1100_0000);
      rst = 1'b0;
      #1;
      chk("ar_req", {31'd0, imem_req}, 32'd0);
      chk("ar_addr", imem_addr, 32'd0);
      chk("ar_valid", {31'd0, if_valid}, 32'd0);
      chk("ar_instr", if_instr, 32'd0);
      chk("ar_pc", if_pc, 32'd0);
      chk("ar_halted", {31'd0, halted}, 32'd0);
      id_stall = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("ar_first_req", {31'd0, imem_req}, 32'd1);
      chk("ar_first_addr", imem_addr, 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
